fetch_unit: RTL and testbench

Parametrised instruction-fetch stage, the successor to the fixed PC + adder + single IF/ID register front end. It issues pipelined requests to instruction memory and buffers returned words in a DEPTH-entry prefetch queue. It presents {pc, pc_next, instr} to decode through a valid/ready handshake and supports redirect (branch/jump) with squashing of in-flight wrong-path responses. It sits between instruction memory and the IF/ID boundary of the CPU pipeline.

---
 rtl/fetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_unit.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: pipelined instruction fetch with prefetch queue and redirect squash (FETCH_STATS_EN adds fetch/squash counters)
module fetch_unit #(
    parameter int ADDR_W = 16,
    parameter int INSTR_W = 16,
    parameter int DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int PC_INC = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_en,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [ADDR_W-1:0]  out_pc_next,
    output logic               busy
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]        stat_fetched,
    output logic [31:0]        stat_squashed
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);
    localparam logic [CW:0] CAP = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0] fetch_pc, resp_pc;
    logic [CW-1:0] outstanding, out_nxt, drop_cnt, drop_nxt, q_count;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [INSTR_W-1:0] instr_q [DEPTH];
    logic [ADDR_W-1:0] pc_q [DEPTH];
    logic gnt, rv, drop, push, pop;

    // memory/queue events; rvalid with nothing outstanding (stale after reset) is ignored
    always_comb begin
        gnt = imem_req & imem_gnt;
        rv = imem_rvalid & (outstanding != '0);
        drop = rv & (redirect_valid | (drop_cnt != '0));
        push = rv & ~drop;
        pop = out_valid & out_ready;
        out_nxt = outstanding + CW'(gnt) - CW'(rv);
        drop_nxt = redirect_valid ? out_nxt : drop_cnt - CW'(drop);
    end

    // state register
    always_ff @(posedge clk) state <= reset ? IDLE : state_nxt;

    // next-state logic
    always_comb begin
        state_nxt = (!fetch_en && outstanding == '0) ? IDLE :
                    (state == IDLE) ? (fetch_en ? FETCH : IDLE) :
                    redirect_valid ? ((out_nxt != '0) ? FLUSH : FETCH) :
                    (state == FLUSH && drop_nxt == '0) ? FETCH : state;
    end

    // outputs: credit-limited request, registered queue head
    always_comb begin
        imem_req = fetch_en & ~redirect_valid & (state != IDLE) & (({1'b0, q_count} + {1'b0, outstanding}) < CAP);
        imem_addr = fetch_pc;
        out_valid = (q_count != '0) & ~redirect_valid;
        out_instr = instr_q[rd_ptr];
        out_pc = pc_q[rd_ptr];
        out_pc_next = pc_q[rd_ptr] + INC;
        busy = (outstanding != '0) | (q_count != '0);
    end

    // counters, pointers and PCs; resp_pc is the PC of the next response that will be kept
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            resp_pc <= RESET_PC;
            outstanding <= '0;
            drop_cnt <= '0;
            q_count <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            outstanding <= out_nxt;
            drop_cnt <= drop_nxt;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                resp_pc <= redirect_pc;
                q_count <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (gnt) fetch_pc <= fetch_pc + INC;
                if (push) resp_pc <= resp_pc + INC;
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                q_count <= q_count + CW'(push) - CW'(pop);
            end
        end
    end

    // queue storage
    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr] <= imem_rdata;
            pc_q[wr_ptr] <= resp_pc;
        end
    end

`ifdef FETCH_STATS_EN
    // activity counters: kept responses, and dropped responses plus entries flushed by redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_fetched <= '0;
            stat_squashed <= '0;
        end else begin
            stat_fetched <= stat_fetched + 32'(push);
            stat_squashed <= stat_squashed + 32'(drop) + (redirect_valid ? 32'(q_count) : 32'd0);
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit covering streaming, backpressure, redirect, PC wrap and reset
module tb_fetch_unit;
    logic clk = 1'b0;
    logic reset, fetch_en, redirect_valid, imem_gnt, imem_rvalid, out_ready;
    logic [15:0] redirect_pc, imem_addr, imem_rdata, out_instr, out_pc, out_pc_next;
    logic imem_req, out_valid, busy;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched, stat_squashed;
`endif

    typedef struct {
        logic [15:0] pc;
        int due;
        bit sq;
        bit dead;
    } req_t;
    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
    } ent_t;

    req_t pend[$];
    ent_t exp_q[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lat = 1;
    int hs = 0;
    int m_fetched = 0;
    int m_squashed = 0;
    bit gnt_en = 1'b1;
    logic [15:0] mpc = 16'h0000;

    fetch_unit dut (
        .clk(clk),
        .reset(reset),
        .fetch_en(fetch_en),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc(out_pc),
        .out_pc_next(out_pc_next),
        .busy(busy)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched(stat_fetched),
        .stat_squashed(stat_squashed)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // one clock: drive memory, check outputs, update model, advance to next negedge
    task automatic cycle();
        req_t r;
        ent_t e;
        int live;
        imem_gnt = gnt_en & ~reset;
        imem_rvalid = pend.size() > 0 && pend[0].due <= cyc;
        imem_rdata = imem_rvalid ? mem(pend[0].pc) : 16'h0000;
        #1;
        live = 0;
        foreach (pend[i]) if (!pend[i].dead) live++;
        if (reset) begin
            foreach (pend[i]) pend[i].dead = 1'b1;
            exp_q.delete();
            mpc = 16'h0000;
            m_fetched = 0;
            m_squashed = 0;
        end else begin
            check("busy", busy, (live > 0 || exp_q.size() > 0) ? 1 : 0);
            check("out_valid", out_valid, (exp_q.size() > 0 && !redirect_valid) ? 1 : 0);
            if (redirect_valid || !fetch_en || live + exp_q.size() >= 4) check("req_blocked", imem_req, 0);
            if (imem_req) check("imem_addr", imem_addr, mpc);
            if (out_valid && out_ready) begin
                hs++;
                if (exp_q.size() == 0) check("extra_out", exp_q.size(), 1);
                else begin
                    e = exp_q.pop_front();
                    check("out_pc", out_pc, e.pc);
                    check("out_instr", out_instr, e.instr);
                    check("out_pc_next", out_pc_next, 16'(e.pc + 16'd2));
                end
            end else if (out_valid && exp_q.size() > 0) begin
                check("hold_pc", out_pc, exp_q[0].pc);
                check("hold_instr", out_instr, exp_q[0].instr);
            end
            if (redirect_valid) begin
                m_squashed += exp_q.size();
                exp_q.delete();
                foreach (pend[i]) pend[i].sq = 1'b1;
                mpc = redirect_pc;
            end
            if (imem_req && imem_gnt) begin
                pend.push_back('{pc: mpc, due: cyc + lat, sq: 1'b0, dead: 1'b0});
                mpc = 16'(mpc + 16'd2);
            end
        end
        if (imem_rvalid) begin
            r = pend.pop_front();
            if (!r.dead) begin
                if (r.sq) m_squashed++;
                else begin
                    exp_q.push_back('{pc: r.pc, instr: mem(r.pc)});
                    m_fetched++;
                end
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        fetch_en = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && (pend.size() > 0 || exp_q.size() > 0); i++) cycle();
        cycle();
        check("drain_busy", busy, 0);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            cycle();
            n++;
        end
        #1;
        check(tag, out_valid, 1);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        fetch_en = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0000;
        out_ready = 1'b1;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 16'h0000;
        cycle();
        cycle();
        reset = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_req", imem_req, 0);

        // streaming: first output three cycles after reset release, then one per cycle
        hs = 0;
        repeat (3) cycle();
        check("lat_none", hs, 0);
        cycle();
        check("lat_first", hs, 1);
        hs = 0;
        repeat (20) cycle();
        check("stream_rate", hs, 20);

        // backpressure: queue fills to DEPTH, requests stop, head holds
        out_ready = 1'b0;
        repeat (10) cycle();
        #1;
        check("bp_req", imem_req, 0);
        check("bp_valid", out_valid, 1);
        fetch_en = 1'b0;
        out_ready = 1'b1;
        hs = 0;
        repeat (8) cycle();
        check("bp_entries", hs, 4);
        check("bp_busy", busy, 0);

        // grant holdoff: address held while not granted
        fetch_en = 1'b1;
        gnt_en = 1'b0;
        repeat (4) cycle();
        #1;
        check("holdoff_req", imem_req, 1);
        gnt_en = 1'b1;
        repeat (6) cycle();
        drain();

        // redirect with three outstanding, latency 3
        lat = 3;
        fetch_en = 1'b1;
        n = 0;
        while (pend.size() != 3 && n < 20) begin
            cycle();
            n++;
        end
        check("three_outstanding", pend.size(), 3);
        redirect_valid = 1'b1;
        redirect_pc = 16'h0100;
        cycle();
        redirect_valid = 1'b0;
        lat = 1;
        wait_valid("redir_valid");
        check("redir_pc", out_pc, 16'h0100);
        repeat (4) cycle();

        // redirect coincident with rvalid and a would-be handshake
        n = 0;
        while (!(exp_q.size() > 0 && pend.size() > 0 && pend[0].due <= cyc) && n < 20) begin
            cycle();
            n++;
        end
        check("coincide_setup", (exp_q.size() > 0 && pend.size() > 0) ? 1 : 0, 1);
        redirect_valid = 1'b1;
        redirect_pc = 16'h0200;
        hs = 0;
        cycle();
        check("coincide_no_hs", hs, 0);
        redirect_valid = 1'b0;
        wait_valid("coincide_valid");
        check("coincide_pc", out_pc, 16'h0200);

        // PC wrap
        redirect_valid = 1'b1;
        redirect_pc = 16'hFFFC;
        cycle();
        redirect_valid = 1'b0;
        wait_valid("wrap_valid");
        check("wrap_pc0", out_pc, 16'hFFFC);
        cycle();
        #1;
        check("wrap_pc1", out_pc, 16'hFFFE);
        check("wrap_next1", out_pc_next, 16'h0000);
        cycle();
        #1;
        check("wrap_pc2", out_pc, 16'h0000);
        repeat (3) cycle();
        drain();

        // reset with two outstanding and two queued
        lat = 3;
        out_ready = 1'b0;
        fetch_en = 1'b1;
        n = 0;
        while (!(pend.size() == 2 && exp_q.size() == 2) && n < 30) begin
            cycle();
            n++;
        end
        check("reset_setup", pend.size() * 16 + exp_q.size(), 34);
        reset = 1'b1;
        fetch_en = 1'b0;
        cycle();
        reset = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        n = 0;
        while (pend.size() > 0 && n < 20) begin
            cycle();
            n++;
        end
        check("midrst_idle", busy, 0);
        lat = 1;
        out_ready = 1'b1;
        fetch_en = 1'b1;
        wait_valid("restart_valid");
        check("restart_pc", out_pc, 16'h0000);

        // random mix of grants, latency, backpressure and redirects
        for (int i = 0; i < 250; i++) begin
            gnt_en = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            lat = int'($urandom_range(1, 3));
            fetch_en = ($urandom_range(0, 7) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc = 16'($urandom_range(0, 32767) * 2);
            cycle();
        end
        redirect_valid = 1'b0;
        gnt_en = 1'b1;
        drain();
`ifdef FETCH_STATS_EN
        check("stat_fetched", stat_fetched, m_fetched);
        check("stat_squashed", stat_squashed, m_squashed);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
